iter_divider: RTL and testbench

- Iterative restoring divider for the pipelined MIPS core; the inverse partner of the iterative multiplier.
- Executes div/divu: writes quotient to lo and remainder to hi for later mflo/mfhi.
- Sits beside the multiplier in the execute stage; busy feeds the hazard unit's stall path the same way multstall does.

---
 rtl/iter_divider_pkg.sv | 20 ++
 rtl/iter_divider_div_step.sv | 37 +++
 rtl/iter_divider.sv | 146 ++++++++++++++
 tb/tb_iter_divider.sv | 160 ++++++++++++++++
 4 files changed

// File: rtl/iter_divider_pkg.sv
// Shared definitions for the iterative divider.
//   - div_state_e : divider FSM state encoding (2 bits)
//   - DIV_WIDTH   : default operand / result width
//   - FUNCT_DIV / FUNCT_DIVU : R-type funct codes, so the controller and the
//     divider agree on which opcode selects the signed path.
package iter_divider_pkg;

  localparam int DIV_WIDTH = 32;

  localparam logic [5:0] FUNCT_DIV  = 6'b011010;
  localparam logic [5:0] FUNCT_DIVU = 6'b011011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_FIX  = 2'd2,
    ST_DONE = 2'd3
  } div_state_e;

endpackage

// File: rtl/iter_divider_div_step.sv
// One restoring-division step, purely combinational.
// Ports:
//   rem_i / quo_i : current partial remainder and quotient/dividend shift reg
//   div_i         : divisor magnitude
//   rem_o / quo_o : values after shifting one dividend bit in and trying
//                   a subtract
module div_step #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] rem_i,
  input  logic [WIDTH-1:0] quo_i,
  input  logic [WIDTH-1:0] div_i,
  output logic [WIDTH-1:0] rem_o,
  output logic [WIDTH-1:0] quo_o
);

  logic [WIDTH:0]   shifted;
  logic [WIDTH+1:0] trial;
  logic             fits;

  always_comb begin
    // {rem,quo} << 1: the dividend MSB moves into the remainder
    shifted = {rem_i, quo_i[WIDTH-1]};
    trial   = {1'b0, shifted} - {2'b00, div_i};
    // Subtract succeeds when the difference is non-negative and fits back
    // into WIDTH bits (the latter always holds while rem < divisor).
    fits    = (trial[WIDTH+1:WIDTH] == 2'b00);
    if (fits) begin
      rem_o = trial[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b1};
    end else begin
      rem_o = shifted[WIDTH-1:0];
      quo_o = {quo_i[WIDTH-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/iter_divider.sv
// Iterative restoring divider for div/divu. Quotient goes to lo, remainder
// to hi. One dividend bit per cycle through a single div_step instance.
// Ports:
//   clk, reset (async, active low)
//   start, is_signed, a (dividend), b (divisor) : request, sampled in IDLE
//   lo, hi        : quotient / remainder registers
//   busy          : stall request (combinationally follows start in IDLE)
//   done          : one-cycle completion pulse
//   div_by_zero   : sticky flag for the last accepted op
module iter_divider
  import iter_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             is_signed,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] lo,
  output logic [WIDTH-1:0] hi,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  div_state_e       state_q, state_d;
  logic [WIDTH-1:0] lo_q, lo_d;
  logic [WIDTH-1:0] hi_q, hi_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             qneg_q, qneg_d;
  logic             rneg_q, rneg_d;
  logic             done_q, done_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH-1:0] a_mag, b_mag;
  logic [WIDTH-1:0] step_rem, step_quo;

  // Magnitudes are plain unsigned WIDTH-bit values; the most negative
  // number negates to itself, which is still its correct magnitude.
  assign a_mag = (is_signed && a[WIDTH-1]) ? -a : a;
  assign b_mag = (is_signed && b[WIDTH-1]) ? -b : b;

  div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i (rem_q),
    .quo_i (quo_q),
    .div_i (dvs_q),
    .rem_o (step_rem),
    .quo_o (step_quo)
  );

  always_comb begin
    state_d = state_q;
    lo_d    = lo_q;
    hi_d    = hi_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    dvs_d   = dvs_q;
    cnt_d   = cnt_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dbz_d   = dbz_q;
    done_d  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          qneg_d = is_signed & (a[WIDTH-1] ^ b[WIDTH-1]);
          rneg_d = is_signed & a[WIDTH-1];
          rem_d  = '0;
          quo_d  = a_mag;
          dvs_d  = b_mag;
          cnt_d  = '0;
          if (b == '0) begin
            // Divide by zero: skip the iterations and publish right away
            state_d = ST_DONE;
            lo_d    = '1;
            hi_d    = a;
            dbz_d   = 1'b1;
            done_d  = 1'b1;
          end else begin
            state_d = ST_CALC;
            dbz_d   = 1'b0;
          end
        end
      end
      ST_CALC: begin
        rem_d = step_rem;
        quo_d = step_quo;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(WIDTH - 1)) state_d = ST_FIX;
      end
      ST_FIX: begin
        lo_d    = qneg_q ? -quo_q : quo_q;
        hi_d    = rneg_q ? -rem_q : rem_q;
        state_d = ST_DONE;
        done_d  = 1'b1;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      lo_q    <= '0;
      hi_q    <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      done_q  <= 1'b0;
      dbz_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lo_q    <= lo_d;
      hi_q    <= hi_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      cnt_q   <= cnt_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      done_q  <= done_d;
      dbz_q   <= dbz_d;
    end
  end

  // In IDLE the stall must rise in the same cycle as the request
  assign busy        = (state_q != ST_IDLE) | start;
  assign done        = done_q;
  assign lo          = lo_q;
  assign hi          = hi_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_iter_divider.sv
module tb_iter_divider;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        is_signed;
  logic [31:0] a, b;
  logic [31:0] lo, hi;
  logic        busy, done, div_by_zero;

  int vecs = 0;
  int errs = 0;

  iter_divider dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .is_signed   (is_signed),
    .a           (a),
    .b           (b),
    .lo          (lo),
    .hi          (hi),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: 64-bit arithmetic, C-style truncating division
  task automatic model(input logic [31:0] av, input logic [31:0] bv, input bit sg,
                       output logic [31:0] q, output logic [31:0] r, output bit z);
    longint sa, sb, lq, lr;
    if (bv == 32'd0) begin
      q = 32'hFFFF_FFFF; r = av; z = 1'b1;
    end else begin
      if (sg) begin
        sa = longint'($signed(av)); sb = longint'($signed(bv));
      end else begin
        sa = longint'({32'd0, av}); sb = longint'({32'd0, bv});
      end
      lq = sa / sb;
      lr = sa % sb;
      q = lq[31:0]; r = lr[31:0]; z = 1'b0;
    end
  endtask

  // Issue one op; optionally pulse a second start at loop step 'inject'
  task automatic do_op(input logic [31:0] av, input logic [31:0] bv, input bit sg, input int inject);
    logic [31:0] eq, er;
    bit ez;
    int n;
    model(av, bv, sg, eq, er, ez);
    @(negedge clk);
    start = 1'b1; a = av; b = bv; is_signed = sg;
    #1 chk("busy_on_start", {31'd0, busy}, 32'd1);
    @(posedge clk);
    n = 1;
    #1 start = 1'b0; a = $urandom; b = $urandom; is_signed = $urandom_range(0, 1);
    while (n < 100) begin
      @(negedge clk);
      if (done) break;
      if (n == 5) chk("busy_calc", {31'd0, busy}, 32'd1);
      if (n == inject) begin
        start = 1'b1; a = $urandom; b = $urandom_range(0, 3);
      end else begin
        start = 1'b0;
      end
      @(posedge clk);
      n++;
    end
    start = 1'b0;
    chk("latency", n, ez ? 32'd1 : 32'd34);
    chk("lo", lo, eq);
    chk("hi", hi, er);
    chk("dbz", {31'd0, div_by_zero}, {31'd0, ez});
    chk("busy_done", {31'd0, busy}, 32'd1);
    @(negedge clk);
    chk("done_pulse", {31'd0, done}, 32'd0);
    chk("busy_idle", {31'd0, busy}, 32'd0);
    if (inject > 0) begin
      n = 0;
      repeat (40) begin
        @(negedge clk);
        if (done) n++;
      end
      chk("extra_done", n, 32'd0);
      chk("lo_hold", lo, eq);
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    reset = 1'b0; start = 1'b0; is_signed = 1'b0; a = '0; b = '0;
    #12;
    chk("rst_lo", lo, 32'd0);
    chk("rst_hi", hi, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_done", {31'd0, done}, 32'd0);
    chk("rst_dbz", {31'd0, div_by_zero}, 32'd0);
    @(negedge clk); reset = 1'b1;

    // Directed cases
    do_op(32'd100, 32'd7, 1'b0, 0);
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1, 0);
    do_op(32'd7, 32'hFFFF_FFFE, 1'b1, 0);
    do_op(32'h1234_5678, 32'd0, 1'b0, 0);
    do_op(32'd50, 32'd5, 1'b1, 0);            // clears sticky flag
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 0);
    do_op(32'hFFFF_FFFF, 32'd1, 1'b0, 0);
    do_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    do_op(32'd3, 32'hFFFF_FFFF, 1'b0, 0);
    do_op(32'hFFFF_FFF0, 32'd0, 1'b1, 0);

    // Start during CALC must be ignored
    do_op(32'd100, 32'd7, 1'b0, 10);

    // Reset during CALC aborts and zeroes results
    @(negedge clk);
    start = 1'b1; a = 32'hDEAD_BEEF; b = 32'd3; is_signed = 1'b0;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (10) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    #1;
    chk("mrst_busy", {31'd0, busy}, 32'd0);
    chk("mrst_done", {31'd0, done}, 32'd0);
    chk("mrst_lo", lo, 32'd0);
    chk("mrst_hi", hi, 32'd0);
    @(negedge clk); reset = 1'b1;
    do_op(32'd100, 32'd7, 1'b0, 0);

    // Randomized ops
    for (int i = 0; i < 40; i++) begin
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'd0;
        1: rb = $urandom_range(1, 15);
        2: rb = -$urandom_range(1, 15);
        3: ra = $urandom_range(0, 100);
        4: ra = 32'h8000_0000;
        default: ;
      endcase
      do_op(ra, rb, $urandom_range(0, 1), 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

endmodule
